// File: rtl/stos_pkg.sv
// Shared types and default sizes for the stos_ext hardware stack.
package stos_pkg;

    localparam int unsigned STOS_DATA_ROZM_DEF = 8;
    localparam int unsigned STOS_ROZM_DEF      = 16;
    localparam int unsigned STOS_ZRODLA_DEF    = 2;

    typedef enum logic [1:0] {
        PUSTY,
        CZESC,
        PELNY
    } stos_stan_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_PUSH,
        OP_POP,
        OP_ZAMIEN
    } stos_op_e;

endpackage

// File: rtl/stos_mux.sv
// N-way push source selector; a select value outside the source range yields zero.
module stos_mux
    import stos_pkg::*;
#(
    parameter int unsigned STOS_data_rozm = STOS_DATA_ROZM_DEF,
    parameter int unsigned STOS_Zrodla    = STOS_ZRODLA_DEF
) (
    input  logic [$clog2(STOS_Zrodla)-1:0]                i_stos_sel,
    input  logic [STOS_Zrodla-1:0][STOS_data_rozm-1:0]    i_data_in,
    output logic [STOS_data_rozm-1:0]                     o_wdata
);

    localparam int unsigned SW = $clog2(STOS_Zrodla);

    always_comb begin
        o_wdata = '0;
        for (int i = 0; i < int'(STOS_Zrodla); i++) begin
            if (i_stos_sel == SW'(i)) begin
                o_wdata = i_data_in[i];
            end
        end
    end

endmodule

// File: rtl/stos_ext.sv
// Parametrised LIFO stack with registered top word, occupancy FSM and N push sources.
// Define STOS_ERR_EN to add the err_clr input and sticky ovf/udf outputs.
module stos_ext
    import stos_pkg::*;
#(
    parameter int unsigned STOS_data_rozm = STOS_DATA_ROZM_DEF,
    parameter int unsigned STOS_Rozm      = STOS_ROZM_DEF,
    parameter int unsigned STOS_Zrodla    = STOS_ZRODLA_DEF
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_push,
    input  logic                                          i_pop,
    input  logic [$clog2(STOS_Zrodla)-1:0]                i_stos_sel,
    input  logic [STOS_Zrodla-1:0][STOS_data_rozm-1:0]    i_data_in,
    output logic [STOS_data_rozm-1:0]                     o_data_out,
    output logic [$clog2(STOS_Rozm+1)-1:0]                o_count,
    output logic                                          o_full,
    output logic                                          o_empty
`ifdef STOS_ERR_EN
    ,
    input  logic                                          i_err_clr,
    output logic                                          o_ovf,
    output logic                                          o_udf
`endif
);

    localparam int unsigned CW = $clog2(STOS_Rozm + 1);
    localparam int unsigned AW = $clog2(STOS_Rozm);
    localparam int unsigned MD = 1 << AW;

    stos_stan_e                r_stan;
    stos_stan_e                w_stan_nxt;
    stos_op_e                  w_op;
    logic [STOS_data_rozm-1:0] r_top;
    logic [STOS_data_rozm-1:0] r_mem [MD];
    logic [STOS_data_rozm-1:0] w_wdata;
    logic [CW-1:0]             r_count;
    logic [AW-1:0]             w_wr_idx;
    logic [AW-1:0]             w_rd_idx;
    logic                      w_push_ok;
    logic                      w_pop_ok;
    logic                      w_ovf_set;
    logic                      w_udf_set;

    stos_mux #(
        .STOS_data_rozm (STOS_data_rozm),
        .STOS_Zrodla    (STOS_Zrodla)
    ) u_mux (
        .i_stos_sel (i_stos_sel),
        .i_data_in  (i_data_in),
        .o_wdata    (w_wdata)
    );

    // mem holds the words below the top; the next free slot is count-1.
    assign w_wr_idx = AW'(r_count - CW'(1));
    assign w_rd_idx = AW'(r_count - CW'(2));

    always_comb begin
        w_op = OP_NOP;
        if (i_push && i_pop) begin
            w_op = (r_stan == PUSTY) ? OP_PUSH : OP_ZAMIEN;
        end else if (i_push) begin
            w_op = OP_PUSH;
        end else if (i_pop) begin
            w_op = OP_POP;
        end
    end

    assign w_push_ok = (w_op == OP_PUSH) && (r_stan != PELNY);
    assign w_pop_ok  = (w_op == OP_POP) && (r_stan != PUSTY);
    assign w_ovf_set = (w_op == OP_PUSH) && (r_stan == PELNY);
    assign w_udf_set = (w_op == OP_POP) && (r_stan == PUSTY);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stan <= PUSTY;
        end else begin
            r_stan <= w_stan_nxt;
        end
    end

    always_comb begin
        w_stan_nxt = r_stan;
        unique case (r_stan)
            PUSTY: begin
                if (w_push_ok) w_stan_nxt = CZESC;
            end
            CZESC: begin
                if (w_push_ok && (r_count == CW'(STOS_Rozm - 1))) begin
                    w_stan_nxt = PELNY;
                end else if (w_pop_ok && (r_count == CW'(1))) begin
                    w_stan_nxt = PUSTY;
                end
            end
            PELNY: begin
                if (w_pop_ok) w_stan_nxt = CZESC;
            end
            default: w_stan_nxt = PUSTY;
        endcase
    end

    always_comb begin
        o_full     = (r_stan == PELNY);
        o_empty    = (r_stan == PUSTY);
        o_data_out = (r_stan == PUSTY) ? '0 : r_top;
        o_count    = r_count;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_push_ok) begin
            r_top   <= w_wdata;
            r_count <= r_count + CW'(1);
        end else if (w_pop_ok) begin
            r_top   <= (r_count == CW'(1)) ? '0 : r_mem[w_rd_idx];
            r_count <= r_count - CW'(1);
        end else if (w_op == OP_ZAMIEN) begin
            r_top <= w_wdata;
        end
    end

    // Storage array carries no reset; contents are dead once count drops.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push_ok && (r_stan != PUSTY)) begin
            r_mem[w_wr_idx] <= r_top;
        end
    end

`ifdef STOS_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_err_clr) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_udf_set) r_udf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
`else
    logic w_unused;
    assign w_unused = w_ovf_set ^ w_udf_set;
`endif

endmodule

// File: tb/tb_stos_ext.sv
// Self-checking bench for stos_ext (W=8, D=4, N=2): directed table, reset sequence, random vs queue model.
module tb_stos_ext;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
    localparam int unsigned N = 2;

    logic           clk = 1'b0;
    logic           rst, push, pop, sel, clr;
    logic [W-1:0]   pc, acc;
    logic [N-1:0][W-1:0] din;
    logic [W-1:0]   dout;
    logic [2:0]     cnt;
    logic           full, empty, ovf, udf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign din = {acc, pc};

    stos_ext #(
        .STOS_data_rozm (W),
        .STOS_Rozm      (D),
        .STOS_Zrodla    (N)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (push),
        .i_pop      (pop),
        .i_stos_sel (sel),
        .i_data_in  (din),
        .o_data_out (dout),
        .o_count    (cnt),
        .o_full     (full),
        .o_empty    (empty)
`ifdef STOS_ERR_EN
        ,
        .i_err_clr  (clr),
        .o_ovf      (ovf),
        .o_udf      (udf)
`endif
    );

`ifndef STOS_ERR_EN
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    typedef struct {
        logic       rst, push, pop, sel, clr;
        logic [7:0] data;
        logic [7:0] e_out;
        int         e_cnt;
        logic       e_ovf, e_udf;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] mq[$];
    logic       m_ovf, m_udf;

    function automatic vec_t v(logic r, logic pu, logic po, logic s, logic [7:0] d, logic c,
                               logic [7:0] eo, int ec, logic eov, logic eud);
        vec_t t;
        t.rst = r; t.push = pu; t.pop = po; t.sel = s; t.data = d; t.clr = c;
        t.e_out = eo; t.e_cnt = ec; t.e_ovf = eov; t.e_udf = eud;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, logic [7:0] eo, int ec, logic eov, logic eud);
        chk({tag, ".data_out"}, 32'(dout), 32'(eo));
        chk({tag, ".count"}, 32'(cnt), 32'(ec));
        chk({tag, ".full"}, 32'(full), 32'(ec == int'(D)));
        chk({tag, ".empty"}, 32'(empty), 32'(ec == 0));
`ifdef STOS_ERR_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(eov));
        chk({tag, ".udf"}, 32'(udf), 32'(eud));
`endif
    endtask

    // Put the word on the selected source and its complement on the other one.
    task automatic drive(logic r, logic pu, logic po, logic s, logic [7:0] d, logic c);
        rst = r; push = pu; pop = po; sel = s; clr = c;
        pc  = s ? ~d : d;
        acc = s ? d : ~d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: stack as a queue, top at the back.
    task automatic model_step();
        logic [7:0] wd;
        wd = sel ? acc : pc;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (push && pop && mq.size() > 0) begin
                mq[mq.size()-1] = wd;
            end else if (push) begin
                if (mq.size() < int'(D)) mq.push_back(wd);
                else if (!clr) m_ovf = 1'b1;
            end else if (pop) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else if (!clr) m_udf = 1'b1;
            end
            if (clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end
    endtask

    initial begin
        int bias;
        logic [7:0] eo;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        vecs.push_back(v(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 8'hBB, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 8'hBB, 0, 8'hBB, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 8'hAA, 0, 8'hAA, 2, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'hBB, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 8'h01, 0, 8'h01, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 8'h02, 0, 8'h02, 2, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 8'h03, 0, 8'h03, 3, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 8'h04, 0, 8'h04, 4, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 8'h05, 0, 8'h04, 4, 1, 0));
        vecs.push_back(v(0, 1, 1, 1, 8'h06, 0, 8'h06, 4, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h03, 3, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h02, 2, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h01, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 8'h33, 0, 8'h33, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 8'h11, 0, 8'h11, 2, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 8'h22, 0, 8'h22, 2, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h33, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 8'h5A, 0, 8'h5A, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1));
        vecs.push_back(v(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].sel, vecs[i].data,
                  vecs[i].clr);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_cnt, vecs[i].e_ovf,
                      vecs[i].e_udf);
        end

        // Reset asserted mid-build drops all contents, then the stack works again.
        drive(0, 1, 0, 0, 8'h10, 0); step();
        drive(0, 1, 0, 1, 8'h20, 0); step();
        drive(0, 1, 0, 0, 8'h30, 0); step();
        check_all("rst_seq.built", 8'h30, 3, 0, 0);
        drive(1, 1, 0, 1, 8'h40, 0); step();
        check_all("rst_seq.reset", 8'h00, 0, 0, 0);
        drive(0, 1, 0, 1, 8'h77, 0); step();
        check_all("rst_seq.after", 8'h77, 1, 0, 0);

        drive(1, 0, 0, 0, 8'h00, 0);
        model_step();
        step();

        bias = 70;
        for (int c = 0; c < 800; c++) begin
            if ((c % 24) == 0) bias = 100 - bias;
            rst  = ($urandom_range(0, 79) == 0);
            push = ($urandom_range(0, 99) < bias);
            pop  = ($urandom_range(0, 99) < (100 - bias));
            sel  = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 11) == 0);
            pc   = 8'($urandom);
            acc  = 8'($urandom);
            model_step();
            step();
            eo = (mq.size() > 0) ? mq[mq.size()-1] : 8'h00;
            check_all($sformatf("rnd%0d", c), eo, mq.size(), m_ovf, m_udf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
